plab4_net_router_input_ctrl_tdm_arb: RTL and testbench

PLAB4_NET_ROUTER_INPUT_CTRL_TDM_ARB -- requirements
Module: plab4_net_router_input_ctrl_tdm_arb

---
 rtl/plab4_net_router_input_ctrl_tdm_arb.sv | 92 +++++++++
 tb/tb_plab4_net_router_input_ctrl_tdm_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_input_ctrl_tdm_arb.sv
// Router input controller that shares one input port among several security
// domains. Each domain owns the port for a fixed time slot, in strict turn.
module plab4_net_router_input_ctrl_tdm_arb #(
    parameter int         p_router_id    = 0,
    parameter int         p_num_routers  = 8,
    parameter int         p_num_domains  = 2,
    parameter int         p_slot_cycles  = 1,
    parameter int         p_guard        = 0,
    parameter logic [2:0] p_default_reqs = 3'b010,
    localparam int        c_dest_nbits   = $clog2(p_num_routers),
    localparam int        c_dom_nbits    = (p_num_domains > 2) ? $clog2(p_num_domains) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest,
    input  logic [p_num_domains-1:0]              in_val,
    output logic [p_num_domains-1:0]              in_rdy,
    output logic [2:0]                            reqs,
    input  logic [2:0]                            grants,
    output logic [c_dom_nbits-1:0]                domain,
    output logic                                  slot_last
);

    localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam logic [c_slot_nbits-1:0] c_slot_max = c_slot_nbits'(p_slot_cycles - 1);
    localparam logic [c_dom_nbits-1:0]  c_dom_max  = c_dom_nbits'(p_num_domains - 1);

    logic [c_slot_nbits-1:0] slot_cnt;
    logic [c_dom_nbits-1:0]  dom_cnt;
    logic [c_dest_nbits-1:0] cur_dest;
    logic                    cur_val;
    logic [2:0]              route;
    logic                    guard_cycle;
    logic                    xfer;
    int                      fwd;

    // Slot rotation never looks at traffic, so an idle domain still burns its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            dom_cnt  <= '0;
        end else if (slot_cnt == c_slot_max) begin
            slot_cnt <= '0;
            dom_cnt  <= (dom_cnt == c_dom_max) ? '0 : dom_cnt + c_dom_nbits'(1);
        end else begin
            slot_cnt <= slot_cnt + c_slot_nbits'(1);
        end
    end

    // Only the owning domain's fields reach the route logic, which keeps the
    // other domains from influencing any output.
    always_comb begin
        cur_dest = '0;
        cur_val  = 1'b0;
        for (int d = 0; d < p_num_domains; d++) begin
            if (int'(dom_cnt) == d) begin
                cur_dest = dest[d*c_dest_nbits +: c_dest_nbits];
                cur_val  = in_val[d];
            end
        end
    end

    always_comb begin
        fwd = int'(cur_dest) - p_router_id;
        if (fwd < 0) begin
            fwd = fwd + p_num_routers;
        end
        if (fwd == 0) begin
            route = p_default_reqs;
        end else if (fwd <= p_num_routers / 2) begin
            route = 3'b100;
        end else begin
            route = 3'b001;
        end
    end

    assign slot_last   = (slot_cnt == c_slot_max);
    assign guard_cycle = (p_guard == 1) && slot_last;
    assign domain      = dom_cnt;

    // Reset gates the combinational outputs so nothing is issued while held.
    assign reqs = (reset && cur_val && !guard_cycle) ? route : 3'b000;
    assign xfer = |(reqs & grants);

    always_comb begin
        in_rdy = '0;
        for (int d = 0; d < p_num_domains; d++) begin
            in_rdy[d] = xfer && (int'(dom_cnt) == d);
        end
    end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_tdm_arb.sv
// Directed bench for the TDM input controller, exercising four parameter
// configurations side by side from a shared clock and reset.
module tb_plab4_net_router_input_ctrl_tdm_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // A: defaults; grants mirror requests
    logic [5:0] destA;
    logic [1:0] inValA, inRdyA;
    logic [2:0] reqsA, grantsA;
    logic       domainA, slotLastA;
    assign grantsA = reqsA;

    // B: three domains, 4-cycle slots, guard cycle
    logic [8:0] destB;
    logic [2:0] inValB, inRdyB;
    logic [2:0] reqsB, grantsB;
    logic [1:0] domainB;
    logic       slotLastB;

    // C: router 2, route decode
    logic [5:0] destC;
    logic [1:0] inValC, inRdyC;
    logic [2:0] reqsC, grantsC;
    logic       domainC, slotLastC;

    // D: 2-cycle slots, only domain 1 valid, grants always high
    logic [5:0] destD;
    logic [1:0] inValD, inRdyD;
    logic [2:0] reqsD, grantsD;
    logic       domainD, slotLastD;

    plab4_net_router_input_ctrl_tdm_arb u_a (
        .clk(clk), .reset(reset), .dest(destA), .in_val(inValA), .in_rdy(inRdyA),
        .reqs(reqsA), .grants(grantsA), .domain(domainA), .slot_last(slotLastA));

    plab4_net_router_input_ctrl_tdm_arb #(
        .p_num_domains(3), .p_slot_cycles(4), .p_guard(1)) u_b (
        .clk(clk), .reset(reset), .dest(destB), .in_val(inValB), .in_rdy(inRdyB),
        .reqs(reqsB), .grants(grantsB), .domain(domainB), .slot_last(slotLastB));

    plab4_net_router_input_ctrl_tdm_arb #(.p_router_id(2)) u_c (
        .clk(clk), .reset(reset), .dest(destC), .in_val(inValC), .in_rdy(inRdyC),
        .reqs(reqsC), .grants(grantsC), .domain(domainC), .slot_last(slotLastC));

    plab4_net_router_input_ctrl_tdm_arb #(.p_slot_cycles(2)) u_d (
        .clk(clk), .reset(reset), .dest(destD), .in_val(inValD), .in_rdy(inRdyD),
        .reqs(reqsD), .grants(grantsD), .domain(domainD), .slot_last(slotLastD));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k);
        logic [2:0] v;
        case ((k / 2) % 4)
            0:       v = 3'd6;
            1:       v = 3'd7;
            2:       v = 3'd1;
            default: v = 3'd2;
        endcase
        destC = {v, v};
        destD = {3'd3, 3'(k)};
        inValD[0] = 1'b0;
    endtask

    logic [2:0] cReqTab [4] = '{3'b100, 3'b001, 3'b001, 3'b010};
    logic [2:0] bReqTab [3] = '{3'b010, 3'b001, 3'b100};
    int expDomB, expSlotB, expDomD;
    logic expGuardB;

    initial begin
        reset   = 1'b0;
        destA   = {3'd3, 3'd0};
        inValA  = 2'b11;
        destB   = {3'd4, 3'd5, 3'd0};
        inValB  = 3'b111;
        grantsB = 3'b111;
        destC   = '0;
        inValC  = 2'b11;
        grantsC = 3'b000;
        destD   = {3'd3, 3'd0};
        inValD  = 2'b10;
        grantsD = 3'b111;

        #3;
        checkOutput("rst_reqsA", reqsA, 3'b000);
        checkOutput("rst_rdyA", inRdyA, 2'b00);
        checkOutput("rst_domA", domainA, 0);
        checkOutput("rst_reqsB", reqsB, 3'b000);
        checkOutput("rst_rdyB", inRdyB, 3'b000);
        @(posedge clk); #2;
        checkOutput("rst_clk_domA", domainA, 0);
        checkOutput("rst_clk_reqsA", reqsA, 3'b000);

        @(negedge clk); #1;
        reset = 1'b1;
        #1;

        for (int k = 0; k < 24; k++) begin
            applyStimulus(k);
            #1;
            checkOutput("A_dom", domainA, k % 2);
            checkOutput("A_reqs", reqsA, (k % 2) ? 3'b100 : 3'b010);
            checkOutput("A_rdy", inRdyA, (k % 2) ? 2'b10 : 2'b01);

            expSlotB  = k % 4;
            expDomB   = (k / 4) % 3;
            expGuardB = (expSlotB == 3);
            checkOutput("B_dom", domainB, expDomB);
            checkOutput("B_last", slotLastB, expGuardB);
            checkOutput("B_reqs", reqsB, expGuardB ? 3'b000 : bReqTab[expDomB]);
            checkOutput("B_rdy", inRdyB, expGuardB ? 3'b000 : (3'b001 << expDomB));

            checkOutput("C_reqs", reqsC, cReqTab[(k / 2) % 4]);
            checkOutput("C_rdy", inRdyC, 2'b00);

            expDomD = (k / 2) % 2;
            checkOutput("D_dom", domainD, expDomD);
            checkOutput("D_last", slotLastD, k % 2);
            checkOutput("D_reqs", reqsD, expDomD ? 3'b100 : 3'b000);
            checkOutput("D_rdy", inRdyD, expDomD ? 2'b10 : 2'b00);

            if (k != 23) begin
                @(posedge clk); #2;
            end
        end

        // k = 23: second cycle of a domain-1 slot for D
        checkOutput("pre_rst_domD", domainD, 1);
        reset = 1'b0;
        #1;
        checkOutput("arst_reqsD", reqsD, 3'b000);
        checkOutput("arst_rdyD", inRdyD, 2'b00);
        checkOutput("arst_domD", domainD, 0);
        checkOutput("arst_reqsA", reqsA, 3'b000);
        checkOutput("arst_rdyA", inRdyA, 2'b00);
        @(posedge clk); #2;
        checkOutput("hold_rdyD", inRdyD, 2'b00);
        checkOutput("hold_domA", domainA, 0);

        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rel_domD", domainD, 0);
        checkOutput("rel_lastD", slotLastD, 0);
        checkOutput("rel_reqsA", reqsA, 3'b010);
        @(posedge clk); #2;
        checkOutput("rel1_domD", domainD, 0);
        checkOutput("rel1_lastD", slotLastD, 1);
        checkOutput("rel1_domA", domainA, 1);
        @(posedge clk); #2;
        checkOutput("rel2_domD", domainD, 1);
        checkOutput("rel2_rdyD", inRdyD, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
